pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined version of the CPU (IF, ID, EX, MEM, WB).
- Keeps its own shadow of the register-use information for the instructions in EX, MEM and WB.
- From that shadow it generates stall, flush, EX-operand forwarding selects and decode-stage write-back bypass.
- Sits beside the decoder. It consumes per-instruction decode info from ID and the branch outcome resolved in EX.

Parameters:
- ADDR_W, 5, register address width.
- REG_ZERO, 31, always-zero register index (X31). It never creates a hazard, forward or bypass.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rn  in  ADDR_W  first read address
- id_rn_used  in  1  instruction reads Rn
- id_rm  in  ADDR_W  second read address, after Reg2Loc mux (Rm, or Rd for STUR/STURB/CBZ/MOVK)
- id_rm_used  in  1  instruction reads the second port
- id_rd  in  ADDR_W  destination
- id_regwrite  in  1  instruction writes Rd
- id_memread  in  1  instruction is LDUR/LDURB
- ex_brtaken  in  1  branch in EX resolved taken (B, taken B.LT, taken CBZ)
- stall  out  1  hold PC and IF/ID register
- flush_ifid  out  1  zero IF/ID register next edge
- flush_idex  out  1  load bubble into ID/EX next edge
- fwd_a  out  2  EX operand A source: 00 regfile, 10 MEM-stage ALU result, 01 WB value
- fwd_b  out  2  EX operand B source, same encoding
- id_bypass_a  out  1  ID Rn read takes WB write data
- id_bypass_b  out  1  ID second read takes WB write data
- stall_count  out  CNT_W  cycles stalled, saturating

Behaviour:
Shadow state:
- EX stage: {valid, rd, regwrite, memread, rn, rn_used, rm, rm_used}.
- MEM stage: {valid, rd, regwrite, memread}.
- WB stage: {valid, rd, regwrite}.

Reset:
- reset_n low clears all shadow valids and stall_count to 0 immediately (asynchronous).
- All outputs are therefore 0 during reset and in the first cycle after release.
- Reset mid-stall or mid-flush aborts it with no residual stall.

Definitions:
- match(s, r): s.valid & s.regwrite & s.rd==r & r!=REG_ZERO.
- brk = ex.valid & ex_brtaken.
- load_use = id_valid & ex.valid & ex.memread & ((id_rn_used & match(ex,id_rn)) | (id_rm_used & match(ex,id_rm))).

Combinational outputs:
- stall = load_use & !brk. A taken branch wins, because the dependent instruction is squashed anyway.
- flush_ifid = brk.
- flush_idex = brk | load_use.
- fwd_a = 10 if ex.rn_used & match(mem,ex.rn) & !mem.memread; else 01 if ex.rn_used & match(wb,ex.rn); else 00. fwd_b is identical using ex.rm and ex.rm_used.
- MEM always has priority over WB (youngest value).
- A load in MEM matching an EX source is prevented by load_use. A bench assertion flags it if it ever occurs.
- id_bypass_a = id_valid & id_rn_used & match(wb,id_rn). id_bypass_b uses id_rm and id_rm_used. This covers the regfile write landing at the end of WB.

Sequential update every rising edge:
- WB <= MEM, and MEM <= EX. The branch in EX always advances.
- EX <= ID fields with valid = id_valid & !flush_idex; otherwise EX becomes a bubble (valid 0).
- stall_count increments when stall=1 and holds at all-ones.
- Single-cycle latency: the load-use stall lasts exactly one cycle. The next cycle the load is in MEM, the consumer is still in ID, and load_use is 0.
- Back-to-back loads feeding each other stall once per pair.
- Flags need no tracking: they are registered at the end of EX, and B.LT reads them in EX.

Test Plan:
- ADDS X1,X2,X3 then SUBS X4,X1,X5 -> cycle the SUBS is in EX: fwd_a=10, fwd_b=00, stall=0.
- ADDS X1, NOP, then ADDS X6,X7,X1 -> consumer in EX: fwd_b=01. Same producer plus a consumer in ID two behind (producer in WB) -> id_bypass_b=1.
- LDUR X9,[X2,#0] then ADDS X3,X9,X9 -> one cycle with stall=1, flush_idex=1, stall_count 0->1. Next cycle stall=0. Consumer in EX gets fwd_a=fwd_b=01.
- Producer rd=X31 with regwrite=1, consumer reading X31 -> fwd_a=fwd_b=00, no stall, no bypass.
- Load in EX with load_use true while ex_brtaken=1 -> stall=0, flush_ifid=1, flush_idex=1, stall_count unchanged. Next cycle EX valid=0.
- Assert reset_n low during a load-use stall -> stall and all fwd/bypass outputs 0 immediately, stall_count=0. Force stall continuously -> stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for the 5-stage (IF/ID/EX/MEM/WB) CPU.
// It keeps a private shadow of the register-use information of the
// instructions currently in EX, MEM and WB. From that shadow and the decode
// info in ID it generates the load-use stall, the branch/bubble flushes, the
// EX operand forwarding selects and the ID-stage write-back bypass.
//
// Ports
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   id_*                : decode info of the instruction currently in ID
//   ex_brtaken          : branch in EX resolved taken
//   stall               : hold PC and IF/ID
//   flush_ifid          : zero IF/ID on the next edge
//   flush_idex          : load a bubble into ID/EX on the next edge
//   fwd_a / fwd_b       : EX operand source (00 regfile, 10 MEM ALU, 01 WB)
//   id_bypass_a / _b    : ID register read takes WB write data
//   stall_count         : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int REG_ZERO = 31,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rn,
    input  logic              id_rn_used,
    input  logic [ADDR_W-1:0] id_rm,
    input  logic              id_rm_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_brtaken,
    output logic              stall,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              id_bypass_a,
    output logic              id_bypass_b,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

    // Shadow state: EX, MEM, WB
    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q, ex_memread_d;
    logic [ADDR_W-1:0] ex_rn_q, ex_rn_d;
    logic              ex_rn_used_q, ex_rn_used_d;
    logic [ADDR_W-1:0] ex_rm_q, ex_rm_d;
    logic              ex_rm_used_q, ex_rm_used_d;

    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic              mem_regwrite_q, mem_regwrite_d;
    logic              mem_memread_q, mem_memread_d;

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic              wb_regwrite_q, wb_regwrite_d;

    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    // A stage "produces" register r if it is a real, writing instruction
    // whose destination is r, and r is not the hard-wired zero register.
    function automatic logic reg_match(input logic              v,
                                       input logic              rw,
                                       input logic [ADDR_W-1:0] rd,
                                       input logic [ADDR_W-1:0] r);
        return v & rw & (rd == r) & (r != ZERO_REG);
    endfunction

    // Per-operand views: index 0 is the Rn port, index 1 the second port.
    logic [1:0][ADDR_W-1:0] ex_src;
    logic [1:0]             ex_src_used;
    logic [1:0][ADDR_W-1:0] id_src;
    logic [1:0]             id_src_used;
    logic [1:0][1:0]        fwd_sel;
    logic [1:0]             byp_sel;
    logic [1:0]             lu_hit;

    assign ex_src      = {ex_rm_q, ex_rn_q};
    assign ex_src_used = {ex_rm_used_q, ex_rn_used_q};
    assign id_src      = {id_rm, id_rn};
    assign id_src_used = {id_rm_used, id_rn_used};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic mem_hit;
            logic wb_hit;
            // A load in MEM is never a forwarding source: load_use keeps the
            // consumer out of EX until the load has reached WB.
            assign mem_hit = ex_src_used[gi] & ~mem_memread_q &
                             reg_match(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_src[gi]);
            assign wb_hit  = ex_src_used[gi] &
                             reg_match(wb_valid_q, wb_regwrite_q, wb_rd_q, ex_src[gi]);
            // MEM holds the younger value, so it wins over WB.
            assign fwd_sel[gi] = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
            assign byp_sel[gi] = id_valid & id_src_used[gi] &
                                 reg_match(wb_valid_q, wb_regwrite_q, wb_rd_q, id_src[gi]);
            assign lu_hit[gi]  = id_src_used[gi] &
                                 reg_match(ex_valid_q, ex_regwrite_q, ex_rd_q, id_src[gi]);
        end
    endgenerate

    logic brk;
    logic load_use;

    assign brk      = ex_valid_q & ex_brtaken;
    assign load_use = id_valid & ex_valid_q & ex_memread_q & (|lu_hit);

    // A taken branch squashes the dependent instruction, so no stall is needed.
    assign stall       = load_use & ~brk;
    assign flush_ifid  = brk;
    assign flush_idex  = brk | load_use;
    assign fwd_a       = fwd_sel[0];
    assign fwd_b       = fwd_sel[1];
    assign id_bypass_a = byp_sel[0];
    assign id_bypass_b = byp_sel[1];
    assign stall_count = stall_count_q;

    always_comb begin
        // MEM and WB always advance.
        wb_valid_d     = mem_valid_q;
        wb_rd_d        = mem_rd_q;
        wb_regwrite_d  = mem_regwrite_q;
        mem_valid_d    = ex_valid_q;
        mem_rd_d       = ex_rd_q;
        mem_regwrite_d = ex_regwrite_q;
        mem_memread_d  = ex_memread_q;

        // A bubble carries no register use at all, so its flags are cleared
        // together with valid; this keeps it out of every match downstream.
        ex_valid_d     = id_valid & ~flush_idex;
        ex_rd_d        = id_rd;
        ex_rn_d        = id_rn;
        ex_rm_d        = id_rm;
        ex_regwrite_d  = ex_valid_d & id_regwrite;
        ex_memread_d   = ex_valid_d & id_memread;
        ex_rn_used_d   = ex_valid_d & id_rn_used;
        ex_rm_used_d   = ex_valid_d & id_rm_used;

        stall_count_d  = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rn_q        <= '0;
            ex_rn_used_q   <= 1'b0;
            ex_rm_q        <= '0;
            ex_rm_used_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            ex_rn_q        <= ex_rn_d;
            ex_rn_used_q   <= ex_rn_used_d;
            ex_rm_q        <= ex_rm_d;
            ex_rm_used_q   <= ex_rm_used_d;
            mem_valid_q    <= mem_valid_d;
            mem_rd_q       <= mem_rd_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_memread_q  <= mem_memread_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_regwrite_q  <= wb_regwrite_d;
            stall_count_q  <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Bench for pipe_hazard_ctrl. A directed table of instruction sequences with
// hand-derived expected outputs, a randomized run checked against a pipeline
// model, a reset-in-the-middle-of-a-stall sequence and a counter saturation
// run on a narrow-counter instance.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;
    localparam int CNT_S  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rn;
    logic              id_rn_used;
    logic [ADDR_W-1:0] id_rm;
    logic              id_rm_used;
    logic [ADDR_W-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              ex_brtaken;

    logic              stall, flush_ifid, flush_idex;
    logic [1:0]        fwd_a, fwd_b;
    logic              id_bypass_a, id_bypass_b;
    logic [CNT_W-1:0]  stall_count;

    logic              stall_s, flush_ifid_s, flush_idex_s;
    logic [1:0]        fwd_a_s, fwd_b_s;
    logic              id_bypass_a_s, id_bypass_b_s;
    logic [CNT_S-1:0]  stall_count_s;

    pipe_hazard_ctrl #(.ADDR_W(ADDR_W), .REG_ZERO(31), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
        .id_rm(id_rm), .id_rm_used(id_rm_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_brtaken(ex_brtaken),
        .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b),
        .stall_count(stall_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    pipe_hazard_ctrl #(.ADDR_W(ADDR_W), .REG_ZERO(31), .CNT_W(CNT_S)) dut_s (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rn(id_rn), .id_rn_used(id_rn_used),
        .id_rm(id_rm), .id_rm_used(id_rm_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_brtaken(ex_brtaken),
        .stall(stall_s), .flush_ifid(flush_ifid_s), .flush_idex(flush_idex_s),
        .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
        .id_bypass_a(id_bypass_a_s), .id_bypass_b(id_bypass_b_s),
        .stall_count(stall_count_s)
    );

    typedef struct {
        logic              valid;
        logic [ADDR_W-1:0] rn;
        logic              rn_used;
        logic [ADDR_W-1:0] rm;
        logic              rm_used;
        logic [ADDR_W-1:0] rd;
        logic              regwrite;
        logic              memread;
    } instr_t;

    typedef struct {
        int stall, fi, fe, fa, fb, ba, bb, cnt, cnt_s;
    } outs_t;

    typedef struct {
        instr_t id;
        bit     br;
        outs_t  exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Pipeline model: instruction records sitting in EX, MEM and WB.
    instr_t m_ex, m_mem, m_wb;
    int     m_cnt;

    function automatic instr_t ins(bit v, int rn, bit rnu, int rm, bit rmu,
                                   int rd, bit rw, bit mr);
        instr_t i;
        i.valid = v; i.rn = 5'(rn); i.rn_used = rnu; i.rm = 5'(rm); i.rm_used = rmu;
        i.rd = 5'(rd); i.regwrite = rw; i.memread = mr;
        return i;
    endfunction

    function automatic instr_t NOP();               return ins(0, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic instr_t ADD(int d, int n, int m); return ins(1, n, 1, m, 1, d, 1, 0); endfunction
    function automatic instr_t LDR(int d, int n);   return ins(1, n, 1, 0, 0, d, 1, 1); endfunction

    function automatic int sat(int v, int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic outs_t mk_o(int st, int fi, int fe, int fa, int fb,
                                   int ba, int bb, int cnt);
        outs_t o;
        o.stall = st; o.fi = fi; o.fe = fe; o.fa = fa; o.fb = fb;
        o.ba = ba; o.bb = bb; o.cnt = sat(cnt, CNT_W); o.cnt_s = sat(cnt, CNT_S);
        return o;
    endfunction

    // Does the stage instruction s write architectural register r?
    function automatic bit writes(instr_t s, logic [ADDR_W-1:0] r);
        return s.valid && s.regwrite && (s.rd == r) && (r != 5'd31);
    endfunction

    function automatic int src_sel(logic used, logic [ADDR_W-1:0] r);
        if (!m_ex.valid || !used) return 0;
        if (writes(m_mem, r) && !m_mem.memread) return 2;
        if (writes(m_wb, r)) return 1;
        return 0;
    endfunction

    function automatic outs_t model_out(instr_t id, bit br);
        outs_t o;
        bit brk, lu;
        brk = m_ex.valid && br;
        lu  = id.valid && m_ex.valid && m_ex.memread &&
              ((id.rn_used && writes(m_ex, id.rn)) || (id.rm_used && writes(m_ex, id.rm)));
        o.stall = (lu && !brk) ? 1 : 0;
        o.fi    = brk ? 1 : 0;
        o.fe    = (brk || lu) ? 1 : 0;
        o.fa    = src_sel(m_ex.rn_used, m_ex.rn);
        o.fb    = src_sel(m_ex.rm_used, m_ex.rm);
        o.ba    = (id.valid && id.rn_used && writes(m_wb, id.rn)) ? 1 : 0;
        o.bb    = (id.valid && id.rm_used && writes(m_wb, id.rm)) ? 1 : 0;
        o.cnt   = sat(m_cnt, CNT_W);
        o.cnt_s = sat(m_cnt, CNT_S);
        return o;
    endfunction

    function automatic outs_t dut_out();
        outs_t a;
        a.stall = int'(stall); a.fi = int'(flush_ifid); a.fe = int'(flush_idex);
        a.fa = int'(fwd_a); a.fb = int'(fwd_b);
        a.ba = int'(id_bypass_a); a.bb = int'(id_bypass_b);
        a.cnt = int'(stall_count); a.cnt_s = int'(stall_count_s);
        return a;
    endfunction

    task automatic model_reset();
        m_ex = NOP(); m_mem = NOP(); m_wb = NOP(); m_cnt = 0;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(string tag, outs_t a, outs_t e);
        chk({tag, ".stall"},      a.stall, e.stall);
        chk({tag, ".flush_ifid"}, a.fi,    e.fi);
        chk({tag, ".flush_idex"}, a.fe,    e.fe);
        chk({tag, ".fwd_a"},      a.fa,    e.fa);
        chk({tag, ".fwd_b"},      a.fb,    e.fb);
        chk({tag, ".bypass_a"},   a.ba,    e.ba);
        chk({tag, ".bypass_b"},   a.bb,    e.bb);
        chk({tag, ".count"},      a.cnt,   e.cnt);
        chk({tag, ".count_s"},    a.cnt_s, e.cnt_s);
    endtask

    task automatic show(string tag, instr_t id, bit br, outs_t a);
        $display("%-10s t=%0t id v=%0d rn=%0d/%0d rm=%0d/%0d rd=%0d rw=%0d mr=%0d br=%0d -> st=%0d fi=%0d fe=%0d fa=%0d fb=%0d ba=%0d bb=%0d cnt=%0d/%0d",
                 tag, $time, id.valid, id.rn, id.rn_used, id.rm, id.rm_used, id.rd,
                 id.regwrite, id.memread, br, a.stall, a.fi, a.fe, a.fa, a.fb,
                 a.ba, a.bb, a.cnt, a.cnt_s);
    endtask

    // Drive ID inputs away from the active edge and let them settle.
    task automatic apply(instr_t id, bit br);
        @(negedge clk);
        id_valid = id.valid; id_rn = id.rn; id_rn_used = id.rn_used;
        id_rm = id.rm; id_rm_used = id.rm_used; id_rd = id.rd;
        id_regwrite = id.regwrite; id_memread = id.memread; ex_brtaken = br;
        #1;
    endtask

    // Clock edge: the model pipeline shifts exactly as the real pipeline does.
    task automatic advance(instr_t id, bit br);
        outs_t e;
        e = model_out(id, br);
        if (m_ex.valid && m_mem.valid && m_mem.memread &&
            ((m_ex.rn_used && writes(m_mem, m_ex.rn)) || (m_ex.rm_used && writes(m_mem, m_ex.rm)))) begin
            errors++;
            $display("FAIL load_in_mem: load in MEM feeds EX source at t=%0t, got 1 required 0", $time);
        end
        @(posedge clk);
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = id;
        m_ex.valid = id.valid && (e.fe == 0);
        if (e.stall != 0) m_cnt++;
    endtask

    task automatic step_model(string tag, instr_t id, bit br);
        outs_t a;
        apply(id, br);
        a = dut_out();
        cmp(tag, a, model_out(id, br));
        show(tag, id, br, a);
        advance(id, br);
    endtask

    function automatic logic [ADDR_W-1:0] rreg();
        int p = $urandom_range(0, 4);
        return (p == 4) ? 5'd31 : 5'(p);
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid    = ($urandom_range(0, 9) < 8);
        i.rn       = rreg();
        i.rn_used  = 1'($urandom_range(0, 1));
        i.rm       = rreg();
        i.rm_used  = 1'($urandom_range(0, 1));
        i.rd       = rreg();
        i.regwrite = ($urandom_range(0, 9) < 7);
        i.memread  = i.regwrite && ($urandom_range(0, 9) < 4);
        return i;
    endfunction

    initial begin
        vec_t   vecs[$];
        outs_t  z;
        outs_t  a;
        instr_t cur;
        bit     cur_br;
        bit     hold;

        z = mk_o(0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- reset ----------------
        reset_n = 1'b0;
        id_valid = 0; id_rn = '0; id_rn_used = 0; id_rm = '0; id_rm_used = 0;
        id_rd = '0; id_regwrite = 0; id_memread = 0; ex_brtaken = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        cmp("reset", dut_out(), z);
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- directed table ----------------
        // ADDS X1,X2,X3 ; SUBS X4,X1,X5 -> MEM forward on A
        vecs.push_back('{ADD(1, 2, 3), 0, mk_o(0,0,0,0,0,0,0,0)});
        vecs.push_back('{ADD(4, 1, 5), 0, mk_o(0,0,0,0,0,0,0,0)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,2,0,0,0,0)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,0)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,0)});
        // ADDS X1 ; NOP ; ADDS X6,X7,X1 ; ADDS X8,X9,X1 -> WB forward + ID bypass
        vecs.push_back('{ADD(1, 2, 3), 0, mk_o(0,0,0,0,0,0,0,0)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,0)});
        vecs.push_back('{ADD(6, 7, 1), 0, mk_o(0,0,0,0,0,0,0,0)});
        vecs.push_back('{ADD(8, 9, 1), 0, mk_o(0,0,0,0,1,0,1,0)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,0)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,0)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,0)});
        // LDUR X9,[X2] ; ADDS X3,X9,X9 -> one stall, then WB forward
        vecs.push_back('{LDR(9, 2),    0, mk_o(0,0,0,0,0,0,0,0)});
        vecs.push_back('{ADD(3, 9, 9), 0, mk_o(1,0,1,0,0,0,0,0)});
        vecs.push_back('{ADD(3, 9, 9), 0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,1,1,0,0,1)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,1)});
        // X31 producer never creates hazards, forwards or bypasses
        vecs.push_back('{LDR(31, 2),     0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{ADD(4, 31, 31), 0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{ADD(5, 31, 31), 0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{ADD(6, 31, 31), 0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{NOP(),          0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{NOP(),          0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{NOP(),          0, mk_o(0,0,0,0,0,0,0,1)});
        // load-use while the branch in EX is taken: branch wins, EX then empty
        vecs.push_back('{LDR(9, 2),    0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{ADD(3, 9, 9), 1, mk_o(0,1,1,0,0,0,0,1)});
        vecs.push_back('{ADD(3, 9, 9), 1, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,1,1,0,0,1)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,1)});
        // two writers of X1 in MEM and WB: MEM wins; then bypass on A
        vecs.push_back('{ADD(1, 2, 3), 0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{ADD(1, 4, 5), 0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{ADD(6, 1, 1), 0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,2,2,0,0,1)});
        vecs.push_back('{ADD(7, 1, 2), 0, mk_o(0,0,0,0,0,1,0,1)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,1)});
        vecs.push_back('{NOP(),        0, mk_o(0,0,0,0,0,0,0,1)});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].id, vecs[i].br);
            a = dut_out();
            cmp($sformatf("row%0d", i), a, vecs[i].exp);
            show($sformatf("row%0d", i), vecs[i].id, vecs[i].br, a);
            advance(vecs[i].id, vecs[i].br);
        end

        // ---------------- randomized run against the model ----------------
        hold = 0;
        cur  = NOP();
        for (int n = 0; n < 1500; n++) begin
            outs_t e;
            if (!hold) cur = rand_instr();
            cur_br = ($urandom_range(0, 9) == 0);
            e = model_out(cur, cur_br);
            step_model($sformatf("rnd%0d", n), cur, cur_br);
            hold = (e.stall != 0);
        end

        // ---------------- reset in the middle of a stall ----------------
        for (int i = 0; i < 3; i++) step_model("drain", NOP(), 0);
        step_model("rs_a", ADD(1, 2, 3), 0);
        step_model("rs_b", ADD(2, 4, 5), 0);
        step_model("rs_c", LDR(9, 2), 0);
        apply(ADD(3, 9, 1), 0);
        a = dut_out();
        cmp("rs_stall", a, mk_o(1, 0, 1, 2, 0, 0, 1, m_cnt));
        show("rs_stall", ADD(3, 9, 1), 0, a);
        reset_n = 1'b0;
        #1;
        a = dut_out();
        cmp("rs_inrst", a, z);
        show("rs_inrst", ADD(3, 9, 1), 0, a);
        id_valid = 0; id_rn_used = 0; id_rm_used = 0; id_regwrite = 0; id_memread = 0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        apply(ADD(3, 9, 1), 0);
        a = dut_out();
        cmp("rs_after", a, z);
        show("rs_after", ADD(3, 9, 1), 0, a);
        advance(ADD(3, 9, 1), 0);

        // ---------------- counter saturation (narrow instance) ----------------
        for (int g = 0; g < 20; g++) begin
            step_model("sat_ld", LDR(9, 2), 0);
            step_model("sat_use", ADD(3, 9, 9), 0);
            step_model("sat_hold", ADD(3, 9, 9), 0);
        end
        apply(NOP(), 0);
        chk("sat_count_s", int'(stall_count_s), 15);
        chk("sat_count", int'(stall_count), 20);
        advance(NOP(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
